// File: rtl/uart_program_loader.sv
// UART boot loader: receives a framed program image over 8N1 serial, writes it word-by-word
// into instruction RAM and holds the CPU in reset until the image is complete.
// Optional macro LOADER_CHECKSUM_EN adds a trailing 8-bit checksum byte to the frame.
module uart_program_loader #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned    CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [16:0]    DEPTH   = 17'(2 ** ADDR_WIDTH);

  // ---------------------------------------------------------------- RX front end
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e     rx_state_q, rx_state_d;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid, frame_err;
  logic [7:0]    rx_byte;

  // rx_prev_q lags the synchronized line so a start needs a seen-high-then-low transition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state_q <= RX_IDLE;
    else       rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
      RX_START: if (cnt_q == HALF_M1) rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_q == FULL_M1 && bit_idx_q == 3'd7) rx_state_d = RX_STOP;
      RX_STOP:  if (cnt_q == FULL_M1) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q + CW'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
      end
      RX_START: if (cnt_q == HALF_M1) cnt_d = '0;
      RX_DATA: if (cnt_q == FULL_M1) begin
        cnt_d     = '0;
        bit_idx_d = bit_idx_q + 3'd1;
        shift_d   = {rx_s2_q, shift_q[7:1]};
      end
      RX_STOP: if (cnt_q == FULL_M1) begin
        cnt_d      = '0;
        byte_valid = rx_s2_q;
        frame_err  = !rx_s2_q;
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  assign rx_byte = shift_q;

  // ---------------------------------------------------------------- loader FSM
  typedef enum logic [2:0] {L_IDLE, L_LEN_HI, L_LEN_LO, L_DATA, L_CSUM, L_DONE, L_ERROR} ld_state_e;

  ld_state_e             state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           len_n;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           word_q, word_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  assign len_n     = {len_q[15:8], rx_byte};
  assign last_word = (byte_cnt_q == 2'd3) && (word_cnt_q + 16'd1 == len_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= L_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_err && state_q != L_IDLE && state_q != L_DONE) begin
      state_d = L_ERROR;
    end else if (byte_valid) begin
      case (state_q)
        L_IDLE, L_ERROR: if (rx_byte == SYNC_BYTE) state_d = L_LEN_HI;
        L_LEN_HI: state_d = L_LEN_LO;
        L_LEN_LO: begin
          if ({1'b0, len_n} > DEPTH) state_d = L_ERROR;
`ifdef LOADER_CHECKSUM_EN
          else if (len_n == 16'd0)   state_d = L_CSUM;
`else
          else if (len_n == 16'd0)   state_d = L_DONE;
`endif
          else                       state_d = L_DATA;
        end
`ifdef LOADER_CHECKSUM_EN
        L_DATA: if (last_word) state_d = L_CSUM;
        L_CSUM: state_d = (rx_byte == csum_q) ? L_DONE : L_ERROR;
`else
        L_DATA: if (last_word) state_d = L_DONE;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // Status flags follow the state being entered so they change on the same edge
  always_comb begin
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    done_d      = (state_d == L_DONE);
    error_d     = (state_d == L_ERROR);
    cpu_hold_d  = (state_d != L_DONE);
    if (byte_valid) begin
      case (state_q)
        L_IDLE, L_ERROR: if (rx_byte == SYNC_BYTE) begin
          word_cnt_d = '0;
          byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
        L_LEN_HI: len_d[15:8] = rx_byte;
        L_LEN_LO: len_d[7:0]  = rx_byte;
        L_DATA: begin
          word_d[8*byte_cnt_q +: 8] = rx_byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q + rx_byte;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
            mem_wdata_d = word_d;
            word_cnt_d  = word_cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_hold_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_hold_q  <= cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_hold  = cpu_hold_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: serial frames in, RAM writes and status flags checked.
// Adapts to LOADER_CHECKSUM_EN by sending the checksum byte only when the macro is defined.
module tb_uart_program_loader;

  localparam int CPB = 16;
  localparam int AW  = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];

  uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      $display("write addr=%0h data=%08h", mem_addr, mem_wdata);
    end
  end

  task automatic do_reset();
    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic glitch();
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Two-word image 0x00000013, 0x00000137; correct checksum is 0x4B
  task automatic send_std_frame(input logic [7:0] csum, input bit with_glitch);
    send_byte(8'hA5, 1'b1);
    if (with_glitch) glitch();
    send_byte(8'h00, 1'b1);
    if (with_glitch) glitch();
    send_byte(8'h02, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h37, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum, 1'b1);
`else
    if (csum == 8'h00) $display("note: checksum byte not sent in this build");
`endif
    repeat (4) @(negedge clk);
  endtask

  task automatic check_std_writes(input string tag);
    total++; if (wr_addr.size() !== 2) begin bad++; $display("FAIL %s write count: got %0d want 2", tag, wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      total++; if (wr_addr[0] !== 12'h000) begin bad++; $display("FAIL %s addr0: got %h want 000", tag, wr_addr[0]); end
      total++; if (wr_data[0] !== 32'h00000013) begin bad++; $display("FAIL %s data0: got %h want 00000013", tag, wr_data[0]); end
      total++; if (wr_addr[1] !== 12'h001) begin bad++; $display("FAIL %s addr1: got %h want 001", tag, wr_addr[1]); end
      total++; if (wr_data[1] !== 32'h00000137) begin bad++; $display("FAIL %s data1: got %h want 00000137", tag, wr_data[1]); end
    end
  endtask

  task automatic check_flags(input string tag, input logic d, input logic e, input logic h);
    total++; if (done !== d) begin bad++; $display("FAIL %s done: got %b want %b", tag, done, d); end
    total++; if (error !== e) begin bad++; $display("FAIL %s error: got %b want %b", tag, error, e); end
    total++; if (cpu_hold !== h) begin bad++; $display("FAIL %s cpu_hold: got %b want %b", tag, cpu_hold, h); end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset mem_we: got %b want 0", mem_we); end
    total++; if (mem_addr !== 12'h000) begin bad++; $display("FAIL reset mem_addr: got %h want 000", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset mem_wdata: got %h want 0", mem_wdata); end
    check_flags("reset", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_load();
    do_reset();
    send_std_frame(8'h4B, 1'b0);
    check_std_writes("load");
    check_flags("load", 1'b1, 1'b0, 1'b0);
    total++; if (mem_wdata !== 32'h00000137) begin bad++; $display("FAIL load wdata hold: got %h want 00000137", mem_wdata); end
  endtask

  task automatic test_done_ignores();
    wr_addr.delete(); wr_data.delete();
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    total++; if (wr_addr.size() !== 0) begin bad++; $display("FAIL done_ignore writes: got %0d want 0", wr_addr.size()); end
    check_flags("done_ignore", 1'b1, 1'b0, 1'b0);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_csum();
    do_reset();
    send_std_frame(8'h4C, 1'b0);
    check_std_writes("bad_csum");
    check_flags("bad_csum", 1'b0, 1'b1, 1'b1);
    wr_addr.delete(); wr_data.delete();
    send_std_frame(8'h4B, 1'b0);
    check_std_writes("retry");
    check_flags("retry", 1'b1, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_zero_len();
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    total++; if (wr_addr.size() !== 0) begin bad++; $display("FAIL zero_len writes: got %0d want 0", wr_addr.size()); end
    check_flags("zero_len", 1'b1, 1'b0, 1'b1 ^ 1'b1);
  endtask

  task automatic test_length_bounds();
    // N == DEPTH is legal: loader waits for data
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
    check_flags("len_depth", 1'b0, 1'b0, 1'b1);
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    total++; if (wr_addr.size() !== 0) begin bad++; $display("FAIL too_long writes: got %0d want 0", wr_addr.size()); end
    check_flags("too_long", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_frame_err();
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    check_flags("frame_err", 1'b0, 1'b1, 1'b1);
    send_byte(8'h37, 1'b1); send_byte(8'h5A, 1'b1);
    total++; if (wr_addr.size() !== 0) begin bad++; $display("FAIL frame_err writes: got %0d want 0", wr_addr.size()); end
    check_flags("err_sticky", 1'b0, 1'b1, 1'b1);
    // Sync restarts the load; lanes assemble little-endian
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hAA, 1'b1);
`endif
    total++; if (wr_addr.size() !== 1) begin bad++; $display("FAIL recover writes: got %0d want 1", wr_addr.size()); end
    if (wr_addr.size() == 1) begin
      total++; if (wr_data[0] !== 32'h44332211) begin bad++; $display("FAIL recover data: got %h want 44332211", wr_data[0]); end
    end
    check_flags("recover", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1);
    @(negedge clk) rx = 1'b0;
    repeat (CPB * 3) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL mid_reset mem_we: got %b want 0", mem_we); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL mid_reset mem_wdata: got %h want 0", mem_wdata); end
    check_flags("mid_reset", 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rx = 1'b1;
    reset = 1'b0;
    repeat (CPB) @(negedge clk);
    total++; if (wr_addr.size() !== 0) begin bad++; $display("FAIL mid_reset writes: got %0d want 0", wr_addr.size()); end
    send_std_frame(8'h4B, 1'b1);
    check_std_writes("after_reset");
    check_flags("after_reset", 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    test_reset();
    test_load();
    test_done_ignores();
`ifdef LOADER_CHECKSUM_EN
    test_bad_csum();
`endif
    test_zero_len();
    test_length_bounds();
    test_frame_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Writer side of the instruction RAM: receives a program image over UART and writes it word-by-word into the RAM that the CPU fetches from.
- Holds the CPU in reset until the image is complete, so the board boots from a serial download instead of a fixed memory image.
- Sits in top between the UART RX pin, the RAM write port (muxed ahead of the CPU store port) and the CPU reset.

Parameters:
CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200); must be >= 4
ADDR_WIDTH, 12, RAM word-address width; capacity DEPTH = 2**ADDR_WIDTH words
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx  in  1  UART receive line, idle high, asynchronous to clk
mem_we  out  1  RAM write strobe, one-cycle pulse per word
mem_addr  out  ADDR_WIDTH  RAM word address
mem_wdata  out  32  RAM write data
cpu_hold  out  1  high = keep CPU in reset
done  out  1  image loaded successfully (sticky)
error  out  1  frame rejected (sticky until next SYNC_BYTE)

Behaviour:
- Reset: mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, FSM=IDLE, RX idle.
- RX front end: rx passes through a 2-flop synchronizer (reset to 1).
  - A falling edge starts a frame; the line is re-checked at CLKS_PER_BIT/2. If high again, it is a glitch and RX returns to idle.
  - 8 data bits are sampled LSB-first at bit centres, then the stop bit.
  - At the stop-bit centre: stop=1 gives a one-cycle byte_valid with the byte; stop=0 gives a one-cycle frame_err.
- Frame format, all bytes 8N1:
  - SYNC_BYTE
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian
  - N words, each 4 bytes little-endian
  - CSUM: 8-bit sum of all data bytes mod 256
- FSM states, advancing on byte_valid:
  - IDLE: byte == SYNC_BYTE -> LEN_HI; clears error, resets word/byte counters and checksum to 0. Other bytes are ignored.
  - LEN_HI -> LEN_LO.
  - LEN_LO:
    - N > DEPTH -> ERROR.
    - N == 0 -> CSUM.
    - Otherwise -> DATA.
  - DATA:
    - Shift each byte into the word at lane byte_cnt and add it to the checksum.
    - On the 4th byte: on the next clk, mem_we=1 for one cycle, mem_addr=word_cnt, mem_wdata=assembled word. word_cnt increments after the write.
    - When word_cnt reaches N -> CSUM.
  - CSUM: received == running sum -> DONE, else -> ERROR.
  - DONE: done=1, cpu_hold=0 on the clock the FSM enters DONE. All further bytes are ignored; only reset leaves DONE.
  - ERROR: error=1, cpu_hold=1. A SYNC_BYTE restarts a load (as in IDLE); other bytes are ignored.
- frame_err in any state except IDLE/DONE -> ERROR. In IDLE it is ignored.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- mem_we is never asserted outside DATA, and never for word index >= N.
- Words already written before an ERROR stay in RAM; cpu_hold stays 1 regardless.
- Reset mid-frame aborts immediately: outputs return to reset values with no partial-word write. RX resynchronizes on the next falling edge after rx is seen idle-high.
- Byte latency: byte_valid occurs 9.5 bit times after the start-bit falling edge (+2 synchronizer cycles).

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: the CSUM byte is required and compared as described above.
- Undefined: no CSUM byte is expected and no checksum logic is built. The FSM goes DATA -> DONE after the Nth write, and LEN_LO with N == 0 -> DONE.

Test Plan:
- Send A5 00 02 | 13 00 00 00 | 37 01 00 00 | 4B (checksum) -> mem_we pulses twice: addr 0 data 32'h00000013, addr 1 data 32'h00000137; then done=1, cpu_hold=0, error=0.
- Same frame with checksum 4C -> both writes occur, error=1, done=0, cpu_hold=1. A following correct frame -> done=1.
- Send A5 00 00 00 -> no mem_we, done=1. Without LOADER_CHECKSUM_EN, send A5 00 00 -> done=1.
- Send A5 10 01 (N=4097 > DEPTH 4096) -> error=1, no mem_we.
- Drive stop bit low on the 3rd data byte -> error=1, no write at addr 0. Bytes other than A5 afterwards leave error=1.
- Assert reset after 2 bytes of word 0 -> all outputs at reset values. A full retransmitted frame then loads correctly; a 1-cycle-wide low glitch on rx while idle produces no byte.
